spi_xfer_queue: RTL and testbench
=================================

Name: spi_xfer_queue

Overview:
Byte-stream front end that sits directly upstream of spi_master. It buffers host TX bytes in a FIFO and issues one spi_master transfer per byte through the start/wr_data interface. It captures each spi_master rd_data on done into an RX FIFO for the host. It enforces the inter-transfer gap and done-timeout so that the host never drives spi_master directly.

Parameters:
DEPTH, 8, entries per FIFO (power of 2, >=2)
GAP_CYCLES, 2, idle clk cycles between done and the next start (>=1)
TIMEOUT, 1024, clk cycles allowed from start to done before abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
tx_data  in  8  host byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  8  received byte, head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host accepts rx_data
start  out  1  one-cycle pulse to spi_master
wr_data  out  8  byte to spi_master, held stable from start until done
rd_data  in  8  spi_master received byte, sampled when done=1
done  in  1  spi_master transfer-complete pulse
busy  out  1  transfer in flight or TX FIFO non-empty
tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy
rx_level  out  $clog2(DEPTH)+1  RX FIFO occupancy
timeout_err  out  1  sticky; set on done timeout

Behaviour:
- Reset (async, rst=1): both FIFOs empty, state IDLE, start=0, wr_data=0, busy=0, timeout_err=0, tx_ready=1, rx_valid=0, levels=0, timer=0.
- Host handshakes are valid/ready: a transfer occurs on a clk edge where valid&ready=1. A push when tx_ready=1 and a pop by the sequencer in the same cycle are both honoured, and tx_level is unchanged.
- A TX push while full is impossible because tx_ready=0. An RX pop while empty is ignored.
- FIFO pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is signalled when MSBs differ and the rest are equal.
- FSM states: IDLE, LOAD, START, WAIT_DONE, GAP.
- IDLE -> LOAD when TX non-empty and rx_level<DEPTH. RX must have room for the byte before launch. If RX is full, the FSM stalls in IDLE.
- LOAD: pop the TX head into the wr_data register. Next state is START.
- START: start=1 for exactly this cycle, and the timer clears. Next state is WAIT_DONE.
- WAIT_DONE, done=1: push rd_data into RX in this same cycle. Next state is GAP. The RX push cannot overflow because of the IDLE check. An rx pop in the same cycle is allowed.
- WAIT_DONE, timer reaches TIMEOUT-1 without done: set timeout_err. No RX push occurs. Next state is GAP. The byte is lost and the queue continues.
- GAP: count GAP_CYCLES cycles, then go to IDLE. The next start is therefore at least GAP_CYCLES+3 cycles after done.
- done outside WAIT_DONE is ignored.
- wr_data is held from LOAD until the next LOAD.
- start never asserts twice without an intervening done or timeout.
- busy = (state!=IDLE) | (tx_level!=0).
- timeout_err is cleared only by rst.
- rst mid-transfer aborts immediately. spi_master shares rst, so no stale done is expected afterwards. Any done that arrives post-reset in IDLE is ignored.
- Latency: tx push at edge N gives the earliest start=1 in cycle N+3 (IDLE sees non-empty at N+1, LOAD at N+2, START at N+3).

Decomposition:
- spi_pkg: BYTE_W=8 and the typedef enum state_t {IDLE, LOAD, START, WAIT_DONE, GAP}.
- Sub-module spi_sync_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/full/empty/level), instantiated twice, once for TX and once for RX.
- The FSM and timers are in the top module.

Test Plan:
- Single byte: push 0xCA; the master model returns rd_data=~wr_data -> exactly one start pulse with wr_data=0xCA, then RX holds 0x35 and rx_valid=1.
- Burst: push 0xCA, 0xF0, 0x01 back-to-back with the model done 20 cycles after start -> three starts in order, each starting >=GAP_CYCLES+3 cycles after the previous done. RX order is 0x35, 0x0F, 0xFE.
- RX backpressure: hold rx_ready=0 and push DEPTH+2 bytes -> exactly DEPTH transfers occur and the FSM stalls in IDLE with tx_level=2. Releasing rx_ready for one pop gives exactly one more start.
- Full TX: fill DEPTH entries with the model stalled -> tx_ready=0 and a push attempt is dropped. A simultaneous push and pop leaves the level unchanged.
- Timeout: TIMEOUT=16, model never asserts done -> timeout_err=1 at cycle start+16, no RX push, and the next TX byte still launches.
- Reset in WAIT_DONE: assert rst -> all outputs reach reset values asynchronously, and a done pulsed after release causes no RX push.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared byte width and sequencer state type for spi_xfer_queue
package spi_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    GAP
  } state_t;
endpackage

// File: rtl/spi_xfer_queue_if.sv
// rtl/spi_xfer_queue_if.sv - host byte streams plus spi_master start/done handshake
interface spi_xfer_queue_if #(
  parameter int DEPTH = 8
);
  import spi_pkg::*;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              start;
  logic [BYTE_W-1:0] wr_data;
  logic [BYTE_W-1:0] rd_data;
  logic              done;
  logic              busy;
  logic [LW-1:0]     tx_level;
  logic [LW-1:0]     rx_level;
  logic              timeout_err;

  modport master (
    output tx_data, tx_valid, rx_ready, rd_data, done,
    input  tx_ready, rx_data, rx_valid, start, wr_data, busy, tx_level, rx_level, timeout_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, rd_data, done,
    output tx_ready, rx_data, rx_valid, start, wr_data, busy, tx_level, rx_level, timeout_err
  );
endinterface

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - synchronous FIFO with wrap-bit pointers, first-word fall-through
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_xfer_queue.sv
// rtl/spi_xfer_queue.sv - queues host bytes into one spi_master transfer each, collects replies
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1024
) (
  input logic             clk,
  input logic             rst,
  spi_xfer_queue_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t            state, next_state;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic [BYTE_W-1:0] wr_data_q;
  logic [BYTE_W-1:0] tx_dout;
  logic [BYTE_W-1:0] rx_dout;
  logic [LW-1:0]     tx_level;
  logic [LW-1:0]     rx_level;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              start_pulse;
  logic              timeout_hit;
  logic              timeout_err_q;

  assign tx_push     = bus.tx_valid & ~tx_full;
  assign rx_pop      = bus.rx_ready & ~rx_empty;
  assign timeout_hit = (state == WAIT_DONE) && !bus.done && (timer == TW'(TIMEOUT - 1));

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.tx_data),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(bus.rd_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Launch only when RX has room, so the reply push in WAIT_DONE can never overflow.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!tx_empty && !rx_full) next_state = LOAD;
      LOAD:      next_state = START;
      START:     next_state = WAIT_DONE;
      WAIT_DONE: if (bus.done || timeout_hit) next_state = GAP;
      GAP:       if (gap_cnt == GW'(GAP_CYCLES - 1)) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    start_pulse = 1'b0;
    case (state)
      LOAD:      tx_pop = 1'b1;
      START:     start_pulse = 1'b1;
      WAIT_DONE: rx_push = bus.done;
      default:   ;
    endcase
  end

  // Timer is zero in START and counts through WAIT_DONE, so a done with timer == TIMEOUT-1 still wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data_q     <= '0;
      timer         <= '0;
      gap_cnt       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (tx_pop) wr_data_q <= tx_dout;
      timer   <= (state == START || state == WAIT_DONE) ? timer + 1'b1 : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_data     = rx_dout;
  assign bus.rx_valid    = ~rx_empty;
  assign bus.start       = start_pulse;
  assign bus.wr_data     = wr_data_q;
  assign bus.busy        = (state != IDLE) | ~tx_empty;
  assign bus.tx_level    = tx_level;
  assign bus.rx_level    = rx_level;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb/tb_spi_xfer_queue.sv - directed self-checking bench for spi_xfer_queue
module tb_spi_xfer_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  spi_xfer_queue_if #(.DEPTH(8)) bus ();
  spi_xfer_queue_if #(.DEPTH(8)) bus2 ();

  spi_xfer_queue #(.DEPTH(8), .GAP_CYCLES(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  spi_xfer_queue #(.DEPTH(8), .GAP_CYCLES(2), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // spi_master model: answers each start with done after model_delay cycles, rd_data = ~wr_data
  int         model_delay = 5;
  bit         model_stall = 1'b0;
  int         manual_req = 0;
  int         manual_seen = 0;
  int         starts = 0;
  bit         armed = 1'b0;
  int         cnt = 0;
  logic [7:0] start_data [$];
  int         start_cyc [$];
  int         done_cyc [$];

  always @(negedge clk) begin
    bus.done = 1'b0;
    if (rst) begin
      armed = 1'b0;
    end else begin
      if (manual_req != manual_seen) begin
        manual_seen++;
        bus.done    = 1'b1;
        bus.rd_data = 8'h77;
        done_cyc.push_back(cyc);
      end else if (armed) begin
        cnt--;
        if (cnt == 0) begin
          armed       = 1'b0;
          bus.done    = 1'b1;
          bus.rd_data = ~bus.wr_data;
          done_cyc.push_back(cyc);
        end
      end
      if (bus.start) begin
        starts++;
        start_data.push_back(bus.wr_data);
        start_cyc.push_back(cyc);
        armed = !model_stall;
        cnt   = model_delay;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    chk(tag, bus.rx_data, exp);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 500, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.rx_ready  = 1'b0;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;
    bus2.rx_ready = 1'b1;
    bus2.done     = 1'b0;
    bus2.rd_data  = 8'h00;

    // Reset values
    cycles(3);
    chk("rst_tx_ready", bus.tx_ready, 1);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_wr_data", bus.wr_data, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_tx_level", bus.tx_level, 0);
    chk("rst_rx_level", bus.rx_level, 0);
    rst = 1'b0;
    cycles(2);

    // Single byte: start appears three cycles after the push edge
    model_delay = 5;
    push(8'hCA);
    chk("single_no_start_n1", bus.start, 0);
    cycles(1);
    chk("single_no_start_n2", bus.start, 0);
    chk("single_busy", bus.busy, 1);
    cycles(1);
    chk("single_start_n3", bus.start, 1);
    chk("single_wr_data", bus.wr_data, 8'hCA);
    n = 0;
    while (bus.rx_valid !== 1'b1 && n < 50) begin
      cycles(1);
      n++;
    end
    chk("single_rx_valid", bus.rx_valid, 1);
    chk("single_rx_data", bus.rx_data, 8'h35);
    chk("single_start_count", starts, 1);
    wait_idle("single_idle");
    chk("single_wr_data_held", bus.wr_data, 8'hCA);
    pop_expect("single_pop", 8'h35);
    chk("single_rx_empty", bus.rx_level, 0);

    // Burst with done 20 cycles after start; next start exactly GAP_CYCLES+3 after done
    model_delay = 20;
    start_data.delete();
    start_cyc.delete();
    done_cyc.delete();
    push(8'hCA);
    push(8'hF0);
    push(8'h01);
    wait_idle("burst_idle");
    chk("burst_starts", start_data.size(), 3);
    chk("burst_wr0", start_data[0], 8'hCA);
    chk("burst_wr1", start_data[1], 8'hF0);
    chk("burst_wr2", start_data[2], 8'h01);
    chk("burst_gap1", start_cyc[1] - done_cyc[0], 5);
    chk("burst_gap2", start_cyc[2] - done_cyc[1], 5);
    chk("burst_rx_level", bus.rx_level, 3);
    pop_expect("burst_rx0", 8'h35);
    pop_expect("burst_rx1", 8'h0F);
    pop_expect("burst_rx2", 8'hFE);

    // RX backpressure: DEPTH+2 bytes, only DEPTH transfers until the host pops
    model_delay = 3;
    s0 = starts;
    for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
    cycles(150);
    chk("bp_starts", starts - s0, 8);
    chk("bp_rx_level", bus.rx_level, 8);
    chk("bp_tx_level", bus.tx_level, 2);
    chk("bp_busy", bus.busy, 1);
    cycles(20);
    chk("bp_stalled", starts - s0, 8);
    pop_expect("bp_head", 8'hEF);
    cycles(30);
    chk("bp_one_more", starts - s0, 9);
    chk("bp_rx_refull", bus.rx_level, 8);
    chk("bp_tx_level1", bus.tx_level, 1);
    bus.rx_ready = 1'b1;
    n = 0;
    while ((bus.busy !== 1'b0 || bus.rx_valid !== 1'b0) && n < 300) begin
      cycles(1);
      n++;
    end
    bus.rx_ready = 1'b0;
    chk("bp_drain_done", n < 300, 1);
    chk("bp_total_starts", starts - s0, 10);

    // Full TX with the master stalled
    model_stall = 1'b1;
    s0 = starts;
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
    chk("full_tx_level", bus.tx_level, 8);
    chk("full_tx_ready", bus.tx_ready, 0);
    chk("full_one_start", starts - s0, 1);
    bus.tx_data  = 8'hEE;
    bus.tx_valid = 1'b1;
    cycles(1);
    bus.tx_valid = 1'b0;
    chk("full_push_dropped", bus.tx_level, 8);
    #1 manual_req++;
    cycles(7);
    chk("full_after_done_level", bus.tx_level, 7);
    chk("full_second_start", starts - s0, 2);
    chk("full_rx_manual", bus.rx_data, 8'h77);
    #1 manual_req++;
    cycles(5);
    chk("pushpop_level_before", bus.tx_level, 7);
    chk("pushpop_tx_ready", bus.tx_ready, 1);
    bus.tx_data  = 8'h5A;
    bus.tx_valid = 1'b1;
    cycles(1);
    bus.tx_valid = 1'b0;
    chk("pushpop_level_after", bus.tx_level, 7);
    chk("pushpop_start", bus.start, 1);
    chk("pushpop_wr_data", bus.wr_data, 8'hA2);
    chk("no_spurious_timeout", bus.timeout_err, 0);

    // Asynchronous reset while waiting for done
    cycles(2);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_level", bus.tx_level, 0);
    chk("arst_rx_level", bus.rx_level, 0);
    chk("arst_rx_valid", bus.rx_valid, 0);
    chk("arst_tx_ready", bus.tx_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_wr_data", bus.wr_data, 8'h00);
    chk("arst_start", bus.start, 0);
    cycles(1);
    rst = 1'b0;
    model_stall = 1'b0;
    s0 = starts;
    cycles(2);
    #1 manual_req++;
    cycles(6);
    chk("post_rst_done_ignored", bus.rx_level, 0);
    chk("post_rst_no_rx_valid", bus.rx_valid, 0);
    chk("post_rst_no_start", starts - s0, 0);
    chk("post_rst_idle", bus.busy, 0);

    // Timeout on the TIMEOUT=16 instance; the queue continues with the next byte
    bus2.tx_data  = 8'hA1;
    bus2.tx_valid = 1'b1;
    cycles(1);
    bus2.tx_data  = 8'hB2;
    cycles(1);
    bus2.tx_valid = 1'b0;
    n = 0;
    while (bus2.start !== 1'b1 && n < 10) begin
      cycles(1);
      n++;
    end
    chk("to_start_latency", n, 1);
    chk("to_wr_data0", bus2.wr_data, 8'hA1);
    cycles(15);
    chk("to_err_before", bus2.timeout_err, 0);
    cycles(1);
    chk("to_err_set", bus2.timeout_err, 1);
    chk("to_no_rx_push", bus2.rx_level, 0);
    cycles(4);
    chk("to_next_start", bus2.start, 1);
    chk("to_wr_data1", bus2.wr_data, 8'hB2);
    cycles(3);
    chk("to_err_sticky", bus2.timeout_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
